// File: rtl/serial_full_adder.sv
// serial_full_adder
//   Multi-cycle WIDTH-bit adder with carry-in. Each RUN cycle adds
//   BITS_PER_CYCLE bits through a rippled slice of full-adder cells. A carry
//   register links consecutive slices. Operation is controlled by a start/done
//   handshake, so latency can be traded against adder width.
//
//   Optional feature macro: SERIAL_ADD_OVF_EN
//     When defined, adds the registered signed-overflow output ovf.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request; accepted only while busy is low (IDLE or DONE)
//   a, b   WIDTH-bit operands, captured on an accepted start
//   cin    carry-in, captured on an accepted start
//   busy   high while a computation is running
//   done   one-cycle pulse when sum/cout are updated
//   sum    registered WIDTH-bit result
//   cout   registered carry-out
//   ovf    (SERIAL_ADD_OVF_EN only) registered two's-complement overflow
module serial_full_adder #(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int STEPS = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

   if (WIDTH < 1) begin : g_width_chk
      $error("serial_full_adder: WIDTH must be >= 1");
   end
   if ((BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bpc_chk
      $error("serial_full_adder: BITS_PER_CYCLE must divide WIDTH");
   end

   // Ripple chain of full-adder cells; the result's top bit is the slice carry-out.
   function automatic logic [BITS_PER_CYCLE:0] add_slice(
      input logic [BITS_PER_CYCLE-1:0] x,
      input logic [BITS_PER_CYCLE-1:0] y,
      input logic                      c
   );
      logic [BITS_PER_CYCLE:0] r;
      logic                    cy;
      cy = c;
      r  = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         r[i] = x[i] ^ y[i] ^ cy;
         cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
      end
      r[BITS_PER_CYCLE] = cy;
      return r;
   endfunction

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state;
   logic [WIDTH-1:0]        opa;
   logic [WIDTH-1:0]        opb;
   logic                    carry;
   logic [CNT_W-1:0]        cnt;
   logic [BITS_PER_CYCLE:0] slice;
   logic [WIDTH-1:0]        next_res;
   logic                    accept;

`ifdef SERIAL_ADD_OVF_EN
   logic a_msb;
   logic b_msb;
`endif

   // busy is high exactly in RUN, so this also blocks starts while running.
   assign accept = start && !busy;
   assign slice  = add_slice(opa[BITS_PER_CYCLE-1:0], opb[BITS_PER_CYCLE-1:0], carry);

   // Partial sums enter from the MSB side. Only the slices from earlier steps
   // are stored, so the final step's next_res is the complete sum.
   if (STEPS == 1) begin : g_single
      assign next_res = slice[BITS_PER_CYCLE-1:0];
   end else begin : g_multi
      logic [WIDTH-BITS_PER_CYCLE-1:0] res;

      assign next_res = {slice[BITS_PER_CYCLE-1:0], res};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            res <= '0;
         end else if (accept) begin
            res <= '0;
         end else if (state == RUN) begin
            res <= next_res[WIDTH-1:BITS_PER_CYCLE];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         opa   <= '0;
         opb   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (accept) begin
            state <= RUN;
            busy  <= 1'b1;
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
         end else if (state == RUN) begin
            opa   <= opa >> BITS_PER_CYCLE;
            opb   <= opb >> BITS_PER_CYCLE;
            carry <= slice[BITS_PER_CYCLE];
            cnt   <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               sum   <= next_res;
               cout  <= slice[BITS_PER_CYCLE];
`ifdef SERIAL_ADD_OVF_EN
               ovf   <= (a_msb == b_msb) && (next_res[WIDTH-1] != a_msb);
`endif
            end
         end else if (state == DONE) begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: doc/serial_full_adder.md
Name: serial_full_adder

Overview:
- Multi-cycle, parametrised adder that evaluates a WIDTH-bit sum with carry-in.
- Processes BITS_PER_CYCLE bits per clock through a carry-chained slice of full-adder cells.
- Next-generation successor to the single-bit combinational full-adder variants.
- Sits behind a start/done handshake, so an arithmetic controller can trade latency for area.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be >= 1.
- BITS_PER_CYCLE, 1, bits added per RUN cycle; must divide WIDTH exactly. Elaboration error otherwise.
- STEPS, WIDTH/BITS_PER_CYCLE, derived localparam; not user-overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising edge of clk
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while computation is in progress
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE.
  - busy=0, done=0, sum=0, cout=0; internal operand/result shift registers and step counter cleared.
  - Reset mid-computation aborts the operation; no done pulse is produced for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → capture a, b, cin; counter=0; go RUN.
  - RUN: busy=1.
    - Each edge adds the low BITS_PER_CYCLE bits of the operand shift registers plus the carry register.
    - The partial sum shifts into the result register from the MSB side; operands shift right by BITS_PER_CYCLE.
    - The carry register takes the slice carry-out; counter increments.
    - On the edge where counter reaches STEPS-1, go DONE.
  - DONE: done=1 for exactly one cycle.
    - sum and cout updated on entry to DONE.
    - start=1 in DONE is accepted (go RUN, capture new operands); otherwise go IDLE.
- Accept rule: start is accepted only when busy=0, i.e. in IDLE or DONE. start while busy=1 is ignored: no capture, no effect on the running operation.
- Latency: if start is accepted on edge E0, done is high in the cycle following edge E0+STEPS. For example, WIDTH=8 and BITS_PER_CYCLE=1 give 8 cycles.
- Back-to-back throughput: one result every STEPS+1 cycles.
- Result holding: sum and cout hold their value from DONE until the next DONE entry. Inputs a, b and cin may change freely after the capture edge.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1). Carry propagates only within the slice and via the carry register.
- Boundary case WIDTH=BITS_PER_CYCLE: STEPS=1, one RUN cycle, so done appears 1 cycle after capture.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the registered two's-complement signed overflow: (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), using captured operands.
  - ovf updates with sum on DONE entry, resets to 0, and holds like sum.
- Not defined: port ovf absent; no overflow logic or MSB capture registers are synthesised.

Test Plan:
- WIDTH=8, BPC=1; a=8'hFF, b=8'h01, cin=0, start pulse.
  - busy=1 for 8 cycles; then done=1 for one cycle with sum=8'h00, cout=1; busy low in DONE.
- WIDTH=4, BPC=1 and BPC=2: exhaustive a, b in 0..15, cin in 0..1, back-to-back starts asserted in DONE.
  - Every result matches a+b+cin. done spacing is 5 cycles (BPC=1) and 3 cycles (BPC=2).
- WIDTH=8, BPC=1; start with a=8'h12, b=8'h34, then start with a=8'hFF, b=8'hFF at cycle 3.
  - Second start ignored; done at cycle 8 with sum=8'h46, cout=0.
- WIDTH=8, BPC=1: start, then rst_n low at cycle 4 of RUN.
  - busy, done, sum and cout go 0 immediately; no done pulse follows.
  - A fresh start with a=8'h80, b=8'h80, cin=1 then yields sum=8'h01, cout=1.
- SERIAL_ADD_OVF_EN defined, WIDTH=8, BPC=4:
  - a=8'h7F, b=8'h01, cin=0 → sum=8'h80, ovf=1, done 2 cycles after capture.
  - a=8'hFF, b=8'h01 → sum=8'h00, ovf=0.
